// File: rtl/gnn_sched_pkg.sv
// Shared types and constants for the two-layer GNN node scheduler.
// Node/job counts, result width, FSM state encoding and the neighbour-mask table.
package gnn_sched_pkg;

    localparam int unsigned NUM_NODES = 4;
    localparam int unsigned NUM_JOBS  = 8;
    localparam int unsigned NODE_W    = $clog2(NUM_NODES);
    localparam int unsigned JOB_W     = $clog2(NUM_JOBS);
    localparam int unsigned RES_W     = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Bit n set means node n contributes to the aggregation for that row's node.
    localparam logic [NUM_NODES-1:0] NBR_MASK [NUM_NODES] = '{
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

endpackage

// File: rtl/gnn_node_scheduler_if.sv
// Job handshake between the scheduler (master) and the shared DNN engine (slave).
interface gnn_node_scheduler_if;
    import gnn_sched_pkg::*;

    logic                    eng_valid;
    logic                    eng_ready;
    logic                    eng_layer;
    logic [NODE_W-1:0]       eng_node;
    logic [NUM_NODES-1:0]    agg_mask;
    logic                    eng_done;
    logic signed [RES_W-1:0] eng_result;

    modport master (
        output eng_valid, eng_layer, eng_node, agg_mask,
        input  eng_ready, eng_done, eng_result
    );

    modport slave (
        input  eng_valid, eng_layer, eng_node, agg_mask,
        output eng_ready, eng_done, eng_result
    );

endinterface

// File: rtl/gnn_sched_watchdog.sv
// Per-job watchdog: counts enabled cycles and flags the last allowed one.
module gnn_sched_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    // Asserted during the TIMEOUT-th enabled cycle so a same-cycle done can still win.
    assign expired = enable && (count_q == CW'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gnn_node_scheduler.sv
// Sequences layer-1 then layer-2 jobs for every graph node through one shared engine,
// buffering layer-1 results and publishing layer-2 results with a per-job watchdog.
module gnn_node_scheduler
    import gnn_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    gnn_node_scheduler_if.master    eng,
    output logic [NUM_NODES-1:0]    node_clk_en,
    output logic                    y_wr_en,
    output logic [NODE_W-1:0]       y_wr_node,
    output logic                    res_valid,
    output logic [NODE_W-1:0]       res_node,
    output logic signed [RES_W-1:0] res_data,
    output logic [NUM_NODES-1:0]    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    state_e                  state_q, state_d;
    logic [JOB_W-1:0]        job_q, job_d;
    logic                    y_wr_en_q, y_wr_en_d;
    logic [NODE_W-1:0]       y_wr_node_q, y_wr_node_d;
    logic                    res_valid_q, res_valid_d;
    logic [NODE_W-1:0]       res_node_q, res_node_d;
    logic signed [RES_W-1:0] res_data_q, res_data_d;
    logic [NUM_NODES-1:0]    out_ready_q, out_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    wd_expired;
    logic [NODE_W-1:0]       node;
    logic                    active;

    assign node   = job_q[NODE_W-1:0];
    assign active = (state_q != IDLE);

    gnn_sched_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != WAIT),
        .enable  (state_q == WAIT),
        .expired (wd_expired)
    );

    assign eng.eng_valid = (state_q == ISSUE);
    assign eng.eng_layer = job_q[JOB_W-1];
    assign eng.eng_node  = node;
    assign eng.agg_mask  = active ? NBR_MASK[node] : '0;
    assign node_clk_en   = active ? ({{(NUM_NODES-1){1'b0}}, 1'b1} << node) : '0;

    always_comb begin
        state_d     = state_q;
        job_d       = job_q;
        y_wr_en_d   = 1'b0;
        y_wr_node_d = y_wr_node_q;
        res_valid_d = 1'b0;
        res_node_d  = res_node_q;
        res_data_d  = res_data_q;
        out_ready_d = out_ready_q;
        done_d      = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ISSUE;
                    job_d       = '0;
                    out_ready_d = '0;
                    err_d       = 1'b0;
                end
            end
            ISSUE: begin
                if (eng.eng_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (eng.eng_done) begin
                    if (!job_q[JOB_W-1]) begin
                        y_wr_en_d   = 1'b1;
                        y_wr_node_d = node;
                    end else begin
                        res_valid_d       = 1'b1;
                        res_node_d        = node;
                        res_data_d        = eng.eng_result;
                        out_ready_d[node] = 1'b1;
                    end
                    if (job_q == JOB_W'(NUM_JOBS - 1)) begin
                        state_d = IDLE;
                        job_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        job_d   = job_q + JOB_W'(1);
                    end
                end else if (wd_expired) begin
                    state_d = IDLE;
                    job_d   = '0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                job_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            job_q       <= '0;
            y_wr_en_q   <= 1'b0;
            y_wr_node_q <= '0;
            res_valid_q <= 1'b0;
            res_node_q  <= '0;
            res_data_q  <= '0;
            out_ready_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            y_wr_en_q   <= y_wr_en_d;
            y_wr_node_q <= y_wr_node_d;
            res_valid_q <= res_valid_d;
            res_node_q  <= res_node_d;
            res_data_q  <= res_data_d;
            out_ready_q <= out_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign y_wr_en   = y_wr_en_q;
    assign y_wr_node = y_wr_node_q;
    assign res_valid = res_valid_q;
    assign res_node  = res_node_q;
    assign res_data  = res_data_q;
    assign out_ready = out_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gnn_node_scheduler.sv
// Directed bench for gnn_node_scheduler: a cycle-level engine model drives the handshake
// and each scenario task compares recorded observations against hand-derived values.
module tb_gnn_node_scheduler;
    import gnn_sched_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [3:0]              node_clk_en;
    logic                    y_wr_en;
    logic [1:0]              y_wr_node;
    logic                    res_valid;
    logic [1:0]              res_node;
    logic signed [20:0]      res_data;
    logic [3:0]              out_ready;
    logic                    busy, done, err;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cyc;

    int          y_cnt, res_cnt, done_cnt, done_cyc, end_cyc, res_bad, job_bad;
    int          stall_bad, stall_cyc, y_first, idle_bad;
    logic [31:0] issue_bits;
    logic [7:0]  y_bits, res_bits;
    logic [3:0]  first_or;
    logic        first_err;

    gnn_node_scheduler_if eng_if ();

    gnn_node_scheduler #(
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .eng         (eng_if),
        .node_clk_en (node_clk_en),
        .y_wr_en     (y_wr_en),
        .y_wr_node   (y_wr_node),
        .res_valid   (res_valid),
        .res_node    (res_node),
        .res_data    (res_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic signed [20:0] val(input int j);
        return 21'(j * 30011 - 120000);
    endfunction

    function automatic logic [3:0] exp_mask(input int n);
        case (n)
            0:       return 4'b0111;
            1:       return 4'b1011;
            2:       return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [45:0] all_outs();
        return {eng_if.eng_valid, eng_if.eng_layer, eng_if.eng_node, eng_if.agg_mask,
                node_clk_en, y_wr_en, y_wr_node, res_valid, res_node, res_data,
                out_ready, busy, done, err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Engine model: start in cycle 0, done one cycle into WAIT unless told otherwise.
    task automatic run_seq(input int stall_job, input int drop_job, input int late_job,
                           input bit stray);
        int         jb       = 0;
        int         wait_cnt = 0;
        int         stall_n  = 0;
        bit         in_wait  = 1'b0;
        bit         logged   = 1'b0;
        logic [3:0] exp_clk;
        y_cnt = 0; res_cnt = 0; done_cnt = 0; res_bad = 0; job_bad = 0;
        stall_bad = 0; stall_cyc = 0;
        done_cyc = -1; end_cyc = -1; y_first = -1;
        issue_bits = '0; y_bits = '0; res_bits = '0;
        cyc = 0;
        start = 1'b1;
        eng_if.eng_ready = 1'b1;
        eng_if.eng_done  = 1'b0;
        for (int t = 0; t < 200; t++) begin
            step();
            if (cyc == 1) begin
                first_or  = out_ready;
                first_err = err;
            end
            if (y_wr_en) begin
                y_cnt++;
                y_bits = {y_bits[5:0], y_wr_node};
                if (y_first < 0) y_first = cyc;
            end
            if (res_valid) begin
                res_cnt++;
                res_bits = {res_bits[5:0], res_node};
                if (res_data !== val(4 + int'(res_node))) res_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!busy) begin
                end_cyc = cyc;
                break;
            end
            start            = stray;
            eng_if.eng_done  = 1'b0;
            eng_if.eng_ready = 1'b1;
            if (in_wait) begin
                wait_cnt++;
                if (jb != drop_job && wait_cnt == ((jb == late_job) ? 16 : 1)) begin
                    eng_if.eng_done   = 1'b1;
                    eng_if.eng_result = val(jb);
                    in_wait           = 1'b0;
                    jb++;
                end
            end else if (eng_if.eng_valid) begin
                exp_clk = 4'b0001 << (jb % 4);
                if ({eng_if.eng_layer, eng_if.eng_node} !== 3'(jb) ||
                    eng_if.agg_mask !== exp_mask(jb % 4) || node_clk_en !== exp_clk)
                    job_bad++;
                if (!logged) begin
                    issue_bits = {issue_bits[28:0], eng_if.eng_layer, eng_if.eng_node};
                    logged     = 1'b1;
                end
                if (jb == stall_job) begin
                    stall_cyc++;
                    if ({eng_if.eng_layer, eng_if.eng_node, eng_if.agg_mask} !== 7'b0101101)
                        stall_bad++;
                end
                if (jb == stall_job && stall_n < 3) begin
                    eng_if.eng_ready = 1'b0;
                    stall_n++;
                end else begin
                    in_wait  = 1'b1;
                    wait_cnt = 0;
                    logged   = 1'b0;
                end
                if (stray) begin
                    eng_if.eng_done   = 1'b1;
                    eng_if.eng_result = 21'h0ABCD;
                end
            end
        end
        start           = 1'b0;
        eng_if.eng_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total_cnt++;
        if (all_outs() !== '0) $display("FAIL reset_outputs: got %h expected 0", all_outs());
        else pass_cnt++;
        rst               = 1'b0;
        eng_if.eng_done   = 1'b1;
        eng_if.eng_result = val(3);
        step();
        eng_if.eng_done = 1'b0;
        step();
        total_cnt++;
        if (all_outs() !== '0) $display("FAIL idle_stray_done: got %h expected 0", all_outs());
        else pass_cnt++;
    endtask

    task automatic test_nominal();
        run_seq(-1, -1, -1, 1'b0);
        total_cnt++;
        if (issue_bits !== 32'o01234567)
            $display("FAIL nom_issue_order: got %o expected 01234567", issue_bits);
        else pass_cnt++;
        total_cnt++;
        if (job_bad !== 0) $display("FAIL nom_job_fields: got %0d bad expected 0", job_bad);
        else pass_cnt++;
        total_cnt++;
        if (y_cnt !== 4 || y_bits !== 8'h1B)
            $display("FAIL nom_y_wr: got %0d/%h expected 4/1b", y_cnt, y_bits);
        else pass_cnt++;
        total_cnt++;
        if (y_first !== 3) $display("FAIL nom_y_first_cyc: got %0d expected 3", y_first);
        else pass_cnt++;
        total_cnt++;
        if (res_cnt !== 4 || res_bits !== 8'h1B || res_bad !== 0)
            $display("FAIL nom_res: got %0d/%h/%0d expected 4/1b/0", res_cnt, res_bits, res_bad);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc !== 17 || done_cnt !== 1 || end_cyc !== 17)
            $display("FAIL nom_done: got %0d/%0d/%0d expected 17/1/17",
                     done_cyc, done_cnt, end_cyc);
        else pass_cnt++;
        total_cnt++;
        if (out_ready !== 4'hF || err !== 1'b0)
            $display("FAIL nom_final: got %h/%b expected f/0", out_ready, err);
        else pass_cnt++;
        step();
        total_cnt++;
        if (done !== 1'b0 || res_valid !== 1'b0 || node_clk_en !== 4'b0000)
            $display("FAIL nom_after: got %b%b%h expected 000", done, res_valid, node_clk_en);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        run_seq(2, -1, -1, 1'b0);
        total_cnt++;
        if (stall_cyc !== 4 || stall_bad !== 0)
            $display("FAIL bp_stall_stable: got %0d/%0d expected 4/0", stall_cyc, stall_bad);
        else pass_cnt++;
        total_cnt++;
        if (issue_bits !== 32'o01234567 || job_bad !== 0)
            $display("FAIL bp_no_skip: got %o/%0d expected 01234567/0", issue_bits, job_bad);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc !== 20) $display("FAIL bp_done_cyc: got %0d expected 20", done_cyc);
        else pass_cnt++;
        total_cnt++;
        if (y_bits !== 8'h1B || out_ready !== 4'hF)
            $display("FAIL bp_results: got %h/%h expected 1b/f", y_bits, out_ready);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        run_seq(-1, 5, -1, 1'b0);
        total_cnt++;
        if (first_or !== 4'h0) $display("FAIL start_clears_ready: got %h expected 0", first_or);
        else pass_cnt++;
        total_cnt++;
        if (end_cyc !== 28) $display("FAIL to_end_cyc: got %0d expected 28", end_cyc);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL to_err_busy: got %b/%b expected 1/0", err, busy);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt !== 0) $display("FAIL to_no_done: got %0d expected 0", done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (out_ready !== 4'b0001 || res_cnt !== 1 || y_cnt !== 4)
            $display("FAIL to_partial: got %b/%0d/%0d expected 0001/1/4",
                     out_ready, res_cnt, y_cnt);
        else pass_cnt++;
        total_cnt++;
        if (issue_bits !== 32'o012345) $display("FAIL to_issue: got %o expected 12345", issue_bits);
        else pass_cnt++;
        step();
        total_cnt++;
        if (err !== 1'b1) $display("FAIL to_err_sticky: got %b expected 1", err);
        else pass_cnt++;
    endtask

    task automatic test_race();
        run_seq(-1, -1, 5, 1'b0);
        total_cnt++;
        if (first_err !== 1'b0) $display("FAIL start_clears_err: got %b expected 0", first_err);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL race_err: got %b expected 0", err);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc !== 32 || end_cyc !== 32)
            $display("FAIL race_done_cyc: got %0d/%0d expected 32/32", done_cyc, end_cyc);
        else pass_cnt++;
        total_cnt++;
        if (out_ready !== 4'hF || res_bad !== 0 || issue_bits !== 32'o01234567)
            $display("FAIL race_results: got %h/%0d/%o expected f/0/01234567",
                     out_ready, res_bad, issue_bits);
        else pass_cnt++;
    endtask

    task automatic test_midrun_reset();
        cyc              = 0;
        start            = 1'b1;
        eng_if.eng_ready = 1'b1;
        eng_if.eng_done  = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            eng_if.eng_done   = 1'b1;
            eng_if.eng_result = val(k);
            step();
            eng_if.eng_done = 1'b0;
        end
        step();
        total_cnt++;
        if (eng_if.eng_node !== 2'd3 || busy !== 1'b1 || eng_if.eng_valid !== 1'b0)
            $display("FAIL rst_in_job3: got node %0d busy %b valid %b expected 3/1/0",
                     eng_if.eng_node, busy, eng_if.eng_valid);
        else pass_cnt++;
        rst             = 1'b1;
        eng_if.eng_done = 1'b1;
        step();
        rst             = 1'b0;
        eng_if.eng_done = 1'b0;
        total_cnt++;
        if (all_outs() !== '0) $display("FAIL rst_midrun_outs: got %h expected 0", all_outs());
        else pass_cnt++;
        idle_bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (busy || y_wr_en || res_valid || done || eng_if.eng_valid) idle_bad++;
        end
        total_cnt++;
        if (idle_bad !== 0) $display("FAIL rst_quiet: got %0d active cycles expected 0", idle_bad);
        else pass_cnt++;
        run_seq(-1, -1, -1, 1'b0);
        total_cnt++;
        if (done_cyc !== 17 || out_ready !== 4'hF || y_bits !== 8'h1B)
            $display("FAIL rst_rerun: got %0d/%h/%h expected 17/f/1b", done_cyc, out_ready, y_bits);
        else pass_cnt++;
    endtask

    task automatic test_stray();
        run_seq(-1, -1, -1, 1'b1);
        total_cnt++;
        if (issue_bits !== 32'o01234567 || job_bad !== 0)
            $display("FAIL stray_sequence: got %o/%0d expected 01234567/0", issue_bits, job_bad);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc !== 17 || done_cnt !== 1)
            $display("FAIL stray_done: got %0d/%0d expected 17/1", done_cyc, done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (res_bad !== 0 || res_bits !== 8'h1B || y_bits !== 8'h1B)
            $display("FAIL stray_results: got %0d/%h/%h expected 0/1b/1b", res_bad, res_bits, y_bits);
        else pass_cnt++;
        step();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL stray_restart: got busy %b expected 0", busy);
        else pass_cnt++;
    endtask

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        eng_if.eng_ready  = 1'b0;
        eng_if.eng_done   = 1'b0;
        eng_if.eng_result = '0;
        cyc               = 0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_race();
        test_midrun_reset();
        test_stray();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
